// File: rtl/naive_bus_arbiter2.sv
// naive_bus_arbiter2: shares one naive_bus slave between two masters, holding the selection
// while the slave stalls and routing late read data back. Define NAIVE_ARB_RR_EN for round-robin.
module naive_bus_arbiter2 #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_rd_req,
  output logic          m0_rd_gnt,
  input  logic [AW-1:0] m0_rd_addr,
  output logic [DW-1:0] m0_rd_data,
  input  logic          m0_wr_req,
  output logic          m0_wr_gnt,
  input  logic [AW-1:0] m0_wr_addr,
  input  logic [DW-1:0] m0_wr_data,
  input  logic          m1_rd_req,
  output logic          m1_rd_gnt,
  input  logic [AW-1:0] m1_rd_addr,
  output logic [DW-1:0] m1_rd_data,
  input  logic          m1_wr_req,
  output logic          m1_wr_gnt,
  input  logic [AW-1:0] m1_wr_addr,
  input  logic [DW-1:0] m1_wr_data,
  output logic          s_rd_req,
  input  logic          s_rd_gnt,
  output logic [AW-1:0] s_rd_addr,
  input  logic [DW-1:0] s_rd_data,
  output logic          s_wr_req,
  input  logic          s_wr_gnt,
  output logic [AW-1:0] s_wr_addr,
  output logic [DW-1:0] s_wr_data
);

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_hold_id;
  logic   w_hold_id_nxt;
  logic   r_rd_owner_v;
  logic   r_rd_owner;
  logic   w_prio;
  logic   w_m0_act;
  logic   w_m1_act;
  logic   w_hold_valid;
  logic   w_sel_v;
  logic   w_sel;
  logic   w_sel_rd_req;
  logic   w_sel_wr_req;
  logic   w_done;

  assign w_m0_act = m0_rd_req | m0_wr_req;
  assign w_m1_act = m1_rd_req | m1_wr_req;
  // A held master that drops every request releases the hold in the same cycle.
  assign w_hold_valid = (r_state == ST_HOLD) && (r_hold_id ? w_m1_act : w_m0_act);

  always_comb begin
    w_sel_v = 1'b0;
    w_sel   = 1'b0;
    if (w_hold_valid) begin
      w_sel_v = 1'b1;
      w_sel   = r_hold_id;
    end else if (w_m0_act && w_m1_act) begin
      w_sel_v = 1'b1;
      w_sel   = w_prio;
    end else if (w_m0_act) begin
      w_sel_v = 1'b1;
      w_sel   = 1'b0;
    end else if (w_m1_act) begin
      w_sel_v = 1'b1;
      w_sel   = 1'b1;
    end else begin
      w_sel_v = 1'b0;
      w_sel   = 1'b0;
    end
  end

  assign w_sel_rd_req = w_sel ? m1_rd_req : m0_rd_req;
  assign w_sel_wr_req = w_sel ? m1_wr_req : m0_wr_req;
  assign w_done = w_sel_v & (~w_sel_rd_req | s_rd_gnt) & (~w_sel_wr_req | s_wr_gnt);

  assign s_rd_req  = w_sel_v & w_sel_rd_req;
  assign s_rd_addr = w_sel ? m1_rd_addr : m0_rd_addr;
  assign s_wr_req  = w_sel_v & w_sel_wr_req;
  assign s_wr_addr = w_sel ? m1_wr_addr : m0_wr_addr;
  assign s_wr_data = w_sel ? m1_wr_data : m0_wr_data;

  assign m0_rd_gnt = w_sel_v & ~w_sel & s_rd_gnt;
  assign m1_rd_gnt = w_sel_v &  w_sel & s_rd_gnt;
  assign m0_wr_gnt = w_sel_v & ~w_sel & s_wr_gnt;
  assign m1_wr_gnt = w_sel_v &  w_sel & s_wr_gnt;

  // Return data follows the registered owner, not the current selection.
  assign m0_rd_data = (r_rd_owner_v && !r_rd_owner) ? s_rd_data : {DW{1'b0}};
  assign m1_rd_data = (r_rd_owner_v &&  r_rd_owner) ? s_rd_data : {DW{1'b0}};

  always_comb begin
    w_state_nxt   = r_state;
    w_hold_id_nxt = r_hold_id;
    case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (w_sel_v && !w_done) begin
          w_state_nxt   = ST_HOLD;
          w_hold_id_nxt = w_sel;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_hold_id    <= 1'b0;
      r_rd_owner_v <= 1'b0;
      r_rd_owner   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_id    <= w_hold_id_nxt;
      r_rd_owner_v <= s_rd_req & s_rd_gnt;
      r_rd_owner   <= w_sel;
    end
  end

`ifdef NAIVE_ARB_RR_EN
  logic r_prio;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_done) begin
      r_prio <= ~w_sel;
    end else begin
      r_prio <= r_prio;
    end
  end

  assign w_prio = r_prio;
`else
  assign w_prio = 1'b0;
`endif

endmodule

// File: tb/tb_naive_bus_arbiter2.sv
// Self-checking bench for naive_bus_arbiter2: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of selection, hold, priority and read return.
module tb_naive_bus_arbiter2;

`ifdef NAIVE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        m0_rd_req, m1_rd_req, m0_wr_req, m1_wr_req;
  logic        m0_rd_gnt, m1_rd_gnt, m0_wr_gnt, m1_wr_gnt;
  logic [31:0] m0_rd_addr, m1_rd_addr, m0_wr_addr, m1_wr_addr;
  logic [31:0] m0_wr_data, m1_wr_data, m0_rd_data, m1_rd_data;
  logic        s_rd_req, s_rd_gnt, s_wr_req, s_wr_gnt;
  logic [31:0] s_rd_addr, s_rd_data, s_wr_addr, s_wr_data;

  int checks = 0;
  int errors = 0;

  // slave behaviour
  bit          slv_ret_v = 1'b0;
  logic [31:0] slv_ret_addr = 32'h0;

  // reference model state
  bit          mdl_lock = 1'b0;
  int          mdl_lock_id = 0;
  int          mdl_prio = 0;
  bit          mdl_ret_v = 1'b0;
  int          mdl_ret_id = 0;
  logic [31:0] mdl_ret_addr = 32'h0;

  bit          p_rd [2];
  bit          p_wr [2];
  logic [31:0] p_ra [2];
  logic [31:0] p_wa [2];
  logic [31:0] p_wd [2];
  int          p_sel = -1;
  bit          p_done = 1'b0;
  logic [5:0]  exp_ctrl;
  logic [63:0] exp_rdd;
  logic [95:0] exp_fwd;

  logic [5:0]  obs_ctrl;
  logic [63:0] obs_rdd;
  logic [95:0] obs_fwd;
  assign obs_ctrl = {m0_rd_gnt, m1_rd_gnt, m0_wr_gnt, m1_wr_gnt, s_rd_req, s_wr_req};
  assign obs_rdd  = {m0_rd_data, m1_rd_data};
  assign obs_fwd  = {s_rd_addr, s_wr_addr, s_wr_data};

  naive_bus_arbiter2 #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_rd_req(m0_rd_req), .m0_rd_gnt(m0_rd_gnt), .m0_rd_addr(m0_rd_addr), .m0_rd_data(m0_rd_data),
    .m0_wr_req(m0_wr_req), .m0_wr_gnt(m0_wr_gnt), .m0_wr_addr(m0_wr_addr), .m0_wr_data(m0_wr_data),
    .m1_rd_req(m1_rd_req), .m1_rd_gnt(m1_rd_gnt), .m1_rd_addr(m1_rd_addr), .m1_rd_data(m1_rd_data),
    .m1_wr_req(m1_wr_req), .m1_wr_gnt(m1_wr_gnt), .m1_wr_addr(m1_wr_addr), .m1_wr_data(m1_wr_data),
    .s_rd_req(s_rd_req), .s_rd_gnt(s_rd_gnt), .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data),
    .s_wr_req(s_wr_req), .s_wr_gnt(s_wr_gnt), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h0680631B;
  endfunction

  task automatic idle_inputs();
    m0_rd_req = 1'b0; m1_rd_req = 1'b0; m0_wr_req = 1'b0; m1_wr_req = 1'b0;
    s_rd_gnt = 1'b0; s_wr_gnt = 1'b0;
  endtask

  // Waits to mid-cycle and predicts every output from the current inputs and model state.
  task automatic settle();
    bit act0, act1;
    logic [31:0] rdat [2];
    #4;
    p_rd[0] = m0_rd_req; p_rd[1] = m1_rd_req;
    p_wr[0] = m0_wr_req; p_wr[1] = m1_wr_req;
    p_ra[0] = m0_rd_addr; p_ra[1] = m1_rd_addr;
    p_wa[0] = m0_wr_addr; p_wa[1] = m1_wr_addr;
    p_wd[0] = m0_wr_data; p_wd[1] = m1_wr_data;
    act0 = p_rd[0] | p_wr[0];
    act1 = p_rd[1] | p_wr[1];
    if (mdl_lock && (p_rd[mdl_lock_id] || p_wr[mdl_lock_id])) p_sel = mdl_lock_id;
    else if (act0 && act1) p_sel = RR ? mdl_prio : 0;
    else if (act0) p_sel = 0;
    else if (act1) p_sel = 1;
    else p_sel = -1;
    p_done = 1'b0;
    exp_ctrl = 6'b0;
    exp_fwd = 96'h0;
    if (p_sel >= 0) begin
      p_done = (!p_rd[p_sel] || s_rd_gnt) && (!p_wr[p_sel] || s_wr_gnt);
      exp_ctrl[5 - p_sel] = s_rd_gnt;
      exp_ctrl[3 - p_sel] = s_wr_gnt;
      exp_ctrl[1] = p_rd[p_sel];
      exp_ctrl[0] = p_wr[p_sel];
      exp_fwd = {p_ra[p_sel], p_wa[p_sel], p_wd[p_sel]};
    end
    rdat[0] = 32'h0;
    rdat[1] = 32'h0;
    if (mdl_ret_v) rdat[mdl_ret_id] = mem_fn(mdl_ret_addr);
    exp_rdd = {rdat[0], rdat[1]};
  endtask

  task automatic model_commit();
    if (rst) begin
      mdl_lock = 1'b0; mdl_lock_id = 0; mdl_prio = 0; mdl_ret_v = 1'b0; mdl_ret_id = 0;
    end else begin
      mdl_ret_v = (p_sel >= 0) && p_rd[p_sel] && s_rd_gnt;
      if (p_sel >= 0) begin
        mdl_ret_id = p_sel;
        mdl_ret_addr = p_ra[p_sel];
      end
      mdl_lock = (p_sel >= 0) && !p_done;
      if (mdl_lock) mdl_lock_id = p_sel;
      if (RR && p_done) mdl_prio = 1 - p_sel;
    end
  endtask

  // Advances one clock: commits the model, the slave latches granted reads, returns data next cycle.
  task automatic tick();
    bit nxt_v;
    logic [31:0] nxt_a;
    nxt_v = (s_rd_req === 1'b1) && (s_rd_gnt === 1'b1);
    nxt_a = s_rd_addr;
    model_commit();
    @(posedge clk);
    slv_ret_v = nxt_v;
    slv_ret_addr = nxt_a;
    #1;
    s_rd_data = slv_ret_v ? mem_fn(slv_ret_addr) : $urandom();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    settle();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    m0_rd_addr = 32'h0; m1_rd_addr = 32'h0; m0_wr_addr = 32'h0; m1_wr_addr = 32'h0;
    m0_wr_data = 32'h0; m1_wr_data = 32'h0; s_rd_data = 32'h0;
    settle();
    tick();
    settle();
    tick();
    settle();
    checks++;
    if (obs_ctrl !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000", obs_ctrl);
    end
    checks++;
    if (obs_rdd !== 64'h0) begin
      errors++; $display("FAIL reset_rd_data: got %h expected 0", obs_rdd);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    m0_rd_req = 1'b1; m0_rd_addr = 32'h0000_0008; s_rd_gnt = 1'b1;
    settle();
    checks++;
    if (m0_rd_gnt !== 1'b1 || m1_rd_gnt !== 1'b0 || s_rd_addr !== 32'h0000_0008) begin
      errors++; $display("FAIL single_read_gnt: got gnt0=%b gnt1=%b addr=%h expected 1 0 00000008", m0_rd_gnt, m1_rd_gnt, s_rd_addr);
    end
    tick();
    idle_inputs();
    settle();
    checks++;
    if (m0_rd_data !== 32'h0680_6313 || m1_rd_data !== 32'h0) begin
      errors++; $display("FAIL single_read_data: got m0=%h m1=%h expected 06806313 00000000", m0_rd_data, m1_rd_data);
    end
    tick();
  endtask

  task automatic test_contention();
    bit exp_m1;
    do_reset();
    m0_rd_req = 1'b1; m1_rd_req = 1'b1; s_rd_gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m0_rd_addr = $urandom(); m1_rd_addr = $urandom();
      settle();
      exp_m1 = RR && (i % 2 == 1);
      checks++;
      if (m1_rd_gnt !== exp_m1 || m0_rd_gnt !== !exp_m1) begin
        errors++; $display("FAIL contention_order cycle %0d: got gnt0=%b gnt1=%b expected gnt1=%b", i, m0_rd_gnt, m1_rd_gnt, exp_m1);
      end
      checks++;
      if (obs_ctrl !== exp_ctrl) begin
        errors++; $display("FAIL contention_ctrl cycle %0d: got %b expected %b", i, obs_ctrl, exp_ctrl);
      end
      checks++;
      if (obs_rdd !== exp_rdd) begin
        errors++; $display("FAIL contention_rd_data cycle %0d: got %h expected %h", i, obs_rdd, exp_rdd);
      end
      tick();
    end
    m0_rd_req = 1'b0;
    settle();
    checks++;
    if (m1_rd_gnt !== 1'b1 || s_rd_addr !== m1_rd_addr) begin
      errors++; $display("FAIL contention_release: got gnt1=%b addr=%h expected 1 %h", m1_rd_gnt, s_rd_addr, m1_rd_addr);
    end
    checks++;
    if (obs_rdd !== exp_rdd) begin
      errors++; $display("FAIL contention_last_data: got %h expected %h", obs_rdd, exp_rdd);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [31:0] a0, a1;
    do_reset();
    a0 = $urandom(); a1 = $urandom();
    m0_rd_addr = a0; m1_rd_addr = a1;
    m1_rd_req = 1'b1; s_rd_gnt = 1'b0;
    settle();
    tick();
    m0_rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (s_rd_addr !== a1 || m0_rd_gnt !== 1'b0 || s_rd_req !== 1'b1) begin
        errors++; $display("FAIL stall_hold cycle %0d: got addr=%h gnt0=%b req=%b expected %h 0 1", i, s_rd_addr, m0_rd_gnt, s_rd_req, a1);
      end
      tick();
    end
    s_rd_gnt = 1'b1;
    settle();
    checks++;
    if (m1_rd_gnt !== 1'b1 || m0_rd_gnt !== 1'b0) begin
      errors++; $display("FAIL stall_grant: got gnt0=%b gnt1=%b expected 0 1", m0_rd_gnt, m1_rd_gnt);
    end
    tick();
    settle();
    checks++;
    if (s_rd_addr !== a0 || m0_rd_gnt !== 1'b1 || m1_rd_data !== mem_fn(a1) || m0_rd_data !== 32'h0) begin
      errors++; $display("FAIL stall_next: got addr=%h gnt0=%b d1=%h d0=%h expected %h 1 %h 0", s_rd_addr, m0_rd_gnt, m1_rd_data, m0_rd_data, a0, mem_fn(a1));
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_write();
    do_reset();
    m0_wr_req = 1'b1; m0_wr_addr = 32'h0003_0000; m0_wr_data = 32'h0000_0068; s_wr_gnt = 1'b1;
    settle();
    checks++;
    if (s_wr_req !== 1'b1 || s_wr_addr !== 32'h0003_0000 || s_wr_data !== 32'h0000_0068 || m0_wr_gnt !== 1'b1 || m1_wr_gnt !== 1'b0 || s_rd_req !== 1'b0) begin
      errors++; $display("FAIL write_fwd: got req=%b addr=%h data=%h g0=%b g1=%b rdreq=%b expected 1 00030000 00000068 1 0 0", s_wr_req, s_wr_addr, s_wr_data, m0_wr_gnt, m1_wr_gnt, s_rd_req);
    end
    tick();
    idle_inputs();
    settle();
    checks++;
    if (obs_rdd !== 64'h0) begin
      errors++; $display("FAIL write_no_rd_data: got %h expected 0", obs_rdd);
    end
    tick();
  endtask

  task automatic test_rst_hold();
    logic [31:0] a0, a1;
    do_reset();
    a0 = $urandom(); a1 = $urandom();
    m0_rd_addr = a0; m1_rd_addr = a1;
    m1_rd_req = 1'b1; m1_wr_req = 1'b1; s_rd_gnt = 1'b1; s_wr_gnt = 1'b0;
    settle();
    checks++;
    if (m1_rd_gnt !== 1'b1 || m1_wr_gnt !== 1'b0) begin
      errors++; $display("FAIL rst_hold_partial: got rd=%b wr=%b expected 1 0", m1_rd_gnt, m1_wr_gnt);
    end
    tick();
    m0_rd_req = 1'b1;
    rst = 1'b1;
    settle();
    checks++;
    if (m1_rd_data !== mem_fn(a1) || m1_rd_gnt !== 1'b1 || m0_rd_gnt !== 1'b0) begin
      errors++; $display("FAIL rst_hold_pre: got d1=%h g1=%b g0=%b expected %h 1 0", m1_rd_data, m1_rd_gnt, m0_rd_gnt, mem_fn(a1));
    end
    tick();
    rst = 1'b0;
    s_rd_gnt = 1'b0;
    settle();
    checks++;
    if (obs_ctrl[5:2] !== 4'b0 || obs_rdd !== 64'h0) begin
      errors++; $display("FAIL rst_hold_post: got gnts=%b rd_data=%h expected 0000 0", obs_ctrl[5:2], obs_rdd);
    end
    checks++;
    if (s_rd_addr !== a0) begin
      errors++; $display("FAIL rst_hold_released: got addr=%h expected %h", s_rd_addr, a0);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      m0_rd_req = ($urandom_range(0, 2) != 0);
      m1_rd_req = ($urandom_range(0, 2) != 0);
      m0_wr_req = ($urandom_range(0, 3) == 0);
      m1_wr_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        m0_rd_addr = $urandom(); m1_rd_addr = $urandom();
      end
      m0_wr_addr = $urandom(); m1_wr_addr = $urandom();
      m0_wr_data = $urandom(); m1_wr_data = $urandom();
      s_rd_gnt = ($urandom_range(0, 2) != 0);
      s_wr_gnt = ($urandom_range(0, 2) != 0);
      settle();
      checks++;
      if (obs_ctrl !== exp_ctrl) begin
        errors++; $display("FAIL random_ctrl cycle %0d: got %b expected %b", i, obs_ctrl, exp_ctrl);
      end
      checks++;
      if (obs_rdd !== exp_rdd) begin
        errors++; $display("FAIL random_rd_data cycle %0d: got %h expected %h", i, obs_rdd, exp_rdd);
      end
      if (p_sel >= 0) begin
        checks++;
        if (obs_fwd !== exp_fwd) begin
          errors++; $display("FAIL random_fwd cycle %0d: got %h expected %h", i, obs_fwd, exp_fwd);
        end
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_stall();
    test_write();
    test_rst_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/naive_bus_arbiter2.md
Name: naive_bus_arbiter2

Overview:
- Shares one naive_bus slave between two naive_bus masters, for example the instruction ROM between core instruction fetch (m0) and the debug/UART loader (m1).
- Selects at most one master per cycle and forwards its read and write request fields to the slave.
- Routes the slave's one-cycle-late read data back to the master that issued the granted read.
- Keeps fairness state and holds the selection while the slave stalls.

Parameters:
- AW, 32, address width of all rd_addr/wr_addr ports.
- DW, 32, data width of all rd_data/wr_data ports.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- m0_rd_req / m1_rd_req  in  1  master read request.
- m0_rd_gnt / m1_rd_gnt  out  1  master read grant.
- m0_rd_addr / m1_rd_addr  in  AW  master read address.
- m0_rd_data / m1_rd_data  out  DW  master read data, valid the cycle after that master's rd_gnt.
- m0_wr_req / m1_wr_req  in  1  master write request.
- m0_wr_gnt / m1_wr_gnt  out  1  master write grant.
- m0_wr_addr / m1_wr_addr  in  AW  master write address.
- m0_wr_data / m1_wr_data  in  DW  master write data.
- s_rd_req  out  1  slave read request.
- s_rd_gnt  in  1  slave read grant.
- s_rd_addr  out  AW  slave read address.
- s_rd_data  in  DW  slave read data, one cycle after s_rd_gnt.
- s_wr_req  out  1  slave write request.
- s_wr_gnt  in  1  slave write grant.
- s_wr_addr  out  AW  slave write address.
- s_wr_data  out  DW  slave write data.

Behaviour:
- A master is active when its rd_req or wr_req is high.
- Selection (combinational, sel in {0,1}):
  - If hold_valid=1, sel = hold_id.
  - Otherwise, if exactly one master is active, sel = that master.
  - Otherwise, if both are active, sel = prio.
  - Otherwise, no selection; all s_*_req = 0.
- Forwarding:
  - s_rd_req/addr and s_wr_req/addr/data are driven from the selected master.
  - The selected master's rd_gnt/wr_gnt equal s_rd_gnt/s_wr_gnt.
  - The unselected master's gnts are 0.
  - Grant is combinational: 0-cycle added latency on the request path.
- Transaction done: the selected master's every raised req was granted this cycle (rd_req→s_rd_gnt, wr_req→s_wr_gnt).
- Hold state machine, states IDLE and HOLD:
  - IDLE→HOLD when a selection exists and is not done; capture hold_id=sel.
  - HOLD→IDLE on the cycle the held master's transaction is done.
  - HOLD→IDLE also when the held master drops all reqs; that cycle then arbitrates normally.
  - No other master is forwarded while in HOLD.
- Priority pointer prio:
  - Updates on every done cycle to prio = ~sel (the other master).
  - Unchanged otherwise.
- Read-return routing:
  - Register rd_owner_v <= (s_rd_req & s_rd_gnt) and rd_owner <= sel each cycle.
  - Next cycle: m[rd_owner]_rd_data = s_rd_data when rd_owner_v=1; all other master rd_data = 0.
  - Back-to-back reads from alternating masters must each receive their own data.
- Simultaneous events:
  - A granted read and write from the same master in one cycle are both forwarded.
  - A read return from the previous owner and a new grant to the other master may occur in the same cycle; routing uses rd_owner, not sel.
- Reset (synchronous, active-high):
  - State IDLE, prio=0, hold_id=0, rd_owner_v=0, rd_owner=0.
  - All master rd_data = 0.
  - Reset asserted mid-HOLD drops the hold on the next edge; a pending read return is discarded.
- Width rule: addresses and data are passed through unmodified, no truncation.

Optional Feature:
- Macro NAIVE_ARB_RR_EN.
- Defined: round-robin via the prio pointer, as described above.
- Not defined: fixed priority.
  - prio is held at 0, so m0 wins every contention.
  - HOLD behaviour and read routing are unchanged.
  - The prio register is not synthesised.

Test Plan:
- Only m0_rd_req=1, addr 0x00000008, slave grants immediately → m0_rd_gnt=1 same cycle; next cycle m0_rd_data = slave data (e.g. 0x06806313); m1_rd_data=0.
- Both masters request reads, slave always grants, RR on → grants alternate m0,m1,m0,m1; each master sees its own address's data one cycle after its grant.
- Both request, RR off → m0 granted every cycle; m1_rd_gnt stays 0 until m0 drops its req.
- m1 selected, slave holds s_rd_gnt=0 for 3 cycles while m0 also requests → s_rd_addr stays m1's address all 3 cycles; m0_rd_gnt=0; after the grant, the next cycle selects m0.
- m0_wr_req with addr 0x00030000, data 0x68, s_wr_gnt=1 → s_wr_addr/s_wr_data match; m0_wr_gnt=1; no rd_data activity.
- Assert rst during HOLD with a read return pending → next cycle all gnts 0, all master rd_data 0, state IDLE, prio=0.
